// File: rtl/ram_bit.sv
// Three-port register-file RAM: two independent registered read ports (A, B)
// and one synchronous write port (C), read-first on same-address collisions.
module ram_bit #(
  parameter int AWIDTH = 8,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] port_a_address,
  output logic [WIDTH-1:0]  port_a_out,
  input  logic [AWIDTH-1:0] port_b_address,
  output logic [WIDTH-1:0]  port_b_out,
  input  logic [AWIDTH-1:0] port_c_address,
  input  logic [WIDTH-1:0]  port_c_data,
  input  logic              port_c_we
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] port_a_out_q;
  logic [WIDTH-1:0] port_b_out_q;
  logic             wr_en;

  // An X/Z enable never matches the if, so wr_en keeps its default and no
  // write happens.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path
    // leaves it unassigned, which would infer a latch.
    wr_en = 1'b0;
    if (port_c_we) wr_en = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the whole array is cleared by the asynchronous reset, so the
      // storage must be flops; a plain SRAM macro cannot be reset like this.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[port_c_address] <= port_c_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_a_out_q <= '0;
      port_b_out_q <= '0;
    end else begin
      // NOTE: non-blocking assignments sample mem_q before this edge's write
      // lands, which is exactly the read-first collision behaviour.
      port_a_out_q <= mem_q[port_a_address];
      port_b_out_q <= mem_q[port_b_address];
    end
  end

  assign port_a_out = port_a_out_q;
  assign port_b_out = port_b_out_q;

endmodule

// File: tb/tb_ram_bit.sv
// Scoreboard bench for ram_bit: expected read data is pushed from a reference
// array when an address is driven and popped when the registered output appears.
module tb_ram_bit;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_addr, b_addr, c_addr, c_data;
  logic       c_we;
  logic [7:0] port_a_out, port_b_out;

  logic [7:0] model [256];
  logic [7:0] exp_a_q [$];
  logic [7:0] exp_b_q [$];
  logic [7:0] exp;
  int checks = 0;
  int errors = 0;

  ram_bit #(.AWIDTH(8), .WIDTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .port_a_address (a_addr),
    .port_a_out     (port_a_out),
    .port_b_address (b_addr),
    .port_b_out     (port_b_out),
    .port_c_address (c_addr),
    .port_c_data    (c_data),
    .port_c_we      (c_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge with inputs already set: queue read expectations
  // (read-first, so before the model write), then advance to the next negedge.
  task automatic drive_cycle(input bit chk_a, input bit chk_b);
    if (chk_a) exp_a_q.push_back(model[a_addr]);
    if (chk_b) exp_b_q.push_back(model[b_addr]);
    if (c_we === 1'b1) model[c_addr] = c_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; c_we = 1'b0; a_addr = '0; b_addr = '0; c_addr = '0; c_data = '0;
    foreach (model[i]) model[i] = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (port_a_out !== 8'h00 || port_b_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: a=%h b=%h required 00/00", port_a_out, port_b_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill;
    for (int k = 0; k < 256; k++) begin
      c_we = 1'b1; c_addr = 8'(k); c_data = 8'(8'hFF - k);
      drive_cycle(0, 0);
    end
    c_we = 1'b0;
    for (int k = 0; k < 256; k++) begin
      a_addr = 8'(k);
      drive_cycle(1, 0);
      exp = exp_a_q.pop_front();
      checks++;
      if (port_a_out !== exp) begin
        errors++;
        $display("FAIL fill_read_a addr=%h: got %h required %h", 8'(k), port_a_out, exp);
      end
    end
  endtask

  task automatic test_port_b_sweep;
    a_addr = 8'h05;
    for (int k = 0; k < 256; k++) begin
      b_addr = 8'(k);
      drive_cycle(1, 1);
      exp = exp_b_q.pop_front();
      checks++;
      if (port_b_out !== exp) begin
        errors++;
        $display("FAIL sweep_b addr=%h: got %h required %h", 8'(k), port_b_out, exp);
      end
      exp = exp_a_q.pop_front();
      checks++;
      if (port_a_out !== exp || port_a_out !== 8'hFA) begin
        errors++;
        $display("FAIL sweep_b_a_stable: got %h required %h", port_a_out, exp);
      end
    end
  endtask

  task automatic test_dual_diff;
    for (int k = 0; k < 255; k++) begin
      a_addr = 8'(k + 1); b_addr = 8'(255 - k);
      drive_cycle(1, 1);
      exp = exp_a_q.pop_front();
      checks++;
      if (port_a_out !== exp) begin
        errors++;
        $display("FAIL dual_diff_a k=%0d: got %h required %h", k, port_a_out, exp);
      end
      exp = exp_b_q.pop_front();
      checks++;
      if (port_b_out !== exp) begin
        errors++;
        $display("FAIL dual_diff_b k=%0d: got %h required %h", k, port_b_out, exp);
      end
    end
  endtask

  task automatic test_dual_same;
    a_addr = 8'h10; b_addr = 8'h10;
    drive_cycle(0, 0);
    checks++;
    if (port_a_out !== 8'hEF || port_b_out !== 8'hEF) begin
      errors++;
      $display("FAIL dual_same_10: a=%h b=%h required EF/EF", port_a_out, port_b_out);
    end
    for (int k = 0; k < 256; k += 37) begin
      a_addr = 8'(k); b_addr = 8'(k);
      drive_cycle(1, 1);
      exp = exp_a_q.pop_front();
      checks++;
      if (port_a_out !== exp || port_b_out !== port_a_out) begin
        errors++;
        $display("FAIL dual_same k=%h: a=%h b=%h required %h", 8'(k), port_a_out, port_b_out, exp);
      end
      void'(exp_b_q.pop_front());
    end
  endtask

  task automatic test_collision;
    a_addr = 8'h20; b_addr = 8'h30; c_addr = 8'h20; c_data = 8'h5A; c_we = 1'b1;
    drive_cycle(1, 1);
    c_we = 1'b0;
    exp = exp_a_q.pop_front();
    checks++;
    if (port_a_out !== exp || port_a_out !== 8'hDF) begin
      errors++;
      $display("FAIL collision_old: got %h required %h", port_a_out, exp);
    end
    exp = exp_b_q.pop_front();
    checks++;
    if (port_b_out !== exp) begin
      errors++;
      $display("FAIL collision_b: got %h required %h", port_b_out, exp);
    end
    drive_cycle(1, 0);
    exp = exp_a_q.pop_front();
    checks++;
    if (port_a_out !== exp || port_a_out !== 8'h5A) begin
      errors++;
      $display("FAIL collision_new: got %h required %h", port_a_out, exp);
    end
  endtask

  task automatic test_x_we;
    c_we = 1'bx; c_addr = 8'h40; c_data = 8'h99;
    drive_cycle(0, 0);
    c_we = 1'b0; a_addr = 8'h40;
    drive_cycle(1, 0);
    exp = exp_a_q.pop_front();
    checks++;
    if (port_a_out !== exp || port_a_out !== 8'hBF) begin
      errors++;
      $display("FAIL x_we_no_write: got %h required %h", port_a_out, exp);
    end
  endtask

  task automatic test_reset_mid_sweep;
    for (int k = 0; k < 20; k++) begin
      a_addr = 8'(k + 60); b_addr = 8'(k + 90);
      drive_cycle(1, 1);
      exp = exp_a_q.pop_front();
      checks++;
      if (port_a_out !== exp) begin
        errors++;
        $display("FAIL presweep_a: got %h required %h", port_a_out, exp);
      end
      void'(exp_b_q.pop_front());
    end
    c_we = 1'b1; c_addr = 8'h33; c_data = 8'hA5;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (port_a_out !== 8'h00 || port_b_out !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: a=%h b=%h required 00/00", port_a_out, port_b_out);
    end
    foreach (model[i]) model[i] = 8'h00;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (port_a_out !== 8'h00 || port_b_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: a=%h b=%h required 00/00", port_a_out, port_b_out);
    end
    c_we = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a_addr = (k == 0) ? 8'h33 : 8'(k * 41); b_addr = 8'(255 - k * 17);
      drive_cycle(1, 1);
      exp = exp_a_q.pop_front();
      checks++;
      if (port_a_out !== exp || port_a_out !== 8'h00) begin
        errors++;
        $display("FAIL post_reset_a addr=%h: got %h required %h", a_addr, port_a_out, exp);
      end
      exp = exp_b_q.pop_front();
      checks++;
      if (port_b_out !== exp || port_b_out !== 8'h00) begin
        errors++;
        $display("FAIL post_reset_b addr=%h: got %h required %h", b_addr, port_b_out, exp);
      end
    end
    c_we = 1'b1; c_addr = 8'h33; c_data = 8'h77;
    drive_cycle(0, 0);
    c_we = 1'b0; a_addr = 8'h33; b_addr = 8'h34;
    drive_cycle(1, 1);
    exp = exp_a_q.pop_front();
    checks++;
    if (port_a_out !== exp || port_a_out !== 8'h77) begin
      errors++;
      $display("FAIL rewrite_a: got %h required %h", port_a_out, exp);
    end
    exp = exp_b_q.pop_front();
    checks++;
    if (port_b_out !== exp) begin
      errors++;
      $display("FAIL rewrite_b: got %h required %h", port_b_out, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_port_b_sweep();
    test_dual_diff();
    test_dual_same();
    test_collision();
    test_x_we();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
